efi_injector_sequencer: RTL and testbench

- Schedules one shared pulse-width timer across NUM_CYL injector outputs.
- Ignition coil edges are the trigger: each edge fires the next cylinder's injector for efi_len_us microseconds.
- Measures the ignition period on the 20 us tick and declares a stall when no edge arrives within a timeout.
- Sits between the realtime counter chain (pulse1m, pulse50k) and the injector drivers, replacing per-injector free-running timers.

---
 rtl/efi_pkg.sv | 20 ++
 rtl/efi_edge_sync.sv | 40 ++++
 rtl/efi_injector_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_efi_injector_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/efi_pkg.sv
// Shared types and constants for the EFI injector sequencer.
package efi_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StPulse,
    StStalled
  } efi_state_e;

  // Ceiling of the ignition-period counter.
  localparam logic [15:0] PERIOD_SAT = 16'hFFFF;

  // Width of the cylinder index; a single-cylinder build still gets one bit.
  function automatic int unsigned cyl_idx_width(input int unsigned num_cyl);
    return (num_cyl <= 1) ? 1 : $clog2(num_cyl);
  endfunction

endpackage

// File: rtl/efi_edge_sync.sv
// Multi-stage synchronizer for an asynchronous level, with a registered rising-edge strobe.
module efi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sysclk,
  input  logic sysreset,
  input  logic din_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_prev_q;
  logic                   rise_q;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];

  // Register the edge so consumers see a clean single-cycle strobe.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      level_prev_q <= level_o;
      rise_q       <= level_o & ~level_prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/efi_injector_sequencer.sv
// Round-robin injector sequencer: each ignition edge opens the next injector for a
// programmed number of microseconds using one shared width timer, while the
// event-to-event period is measured on the 20 us tick for stall detection.
module efi_injector_sequencer
  import efi_pkg::*;
#(
  parameter  int unsigned NUM_CYL     = 2,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned CYL_W       = cyl_idx_width(NUM_CYL)
) (
  input  logic               sysclk,
  input  logic               sysreset,
  input  logic               pulse1m,
  input  logic               pulse50k,
  input  logic               efi_enable,
  input  logic               ign_coil,
  input  logic               cyl_sync,
  input  logic [15:0]        efi_len_us,
  input  logic [15:0]        ign_timeout_len_20us,
  output logic [NUM_CYL-1:0] injector_open,
  output logic               puff_event,
  output logic [CYL_W-1:0]   cyl_index,
  output logic [15:0]        ign_period_20us,
  output logic               stalled,
  output logic               overlap_err
);

  logic coil_rise;
  logic coil_level_unused;
  logic sync_level;
  logic sync_rise_unused;

  efi_state_e   state_q;
  logic [15:0]  width_q;
  logic [15:0]  period_cnt_q;
  logic         period_valid_q;

  logic [CYL_W-1:0]   target;
  logic [CYL_W-1:0]   next_idx;
  logic [NUM_CYL-1:0] target_oh;
  logic [NUM_CYL-1:0] fire_open;
  efi_state_e         fire_state;
  logic               len_nonzero;
  logic               zero_cross;
  logic               timeout_hit;
  logic               stall_entry;

  efi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_coil_sync (
    .sysclk  (sysclk),
    .sysreset(sysreset),
    .din_i   (ign_coil),
    .level_o (coil_level_unused),
    .rise_o  (coil_rise)
  );

  // Only the level matters for cylinder sync; it is sampled when an event fires.
  efi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cyl_sync (
    .sysclk  (sysclk),
    .sysreset(sysreset),
    .din_i   (cyl_sync),
    .level_o (sync_level),
    .rise_o  (sync_rise_unused)
  );

  // Select the cylinder an event fires and the index that follows it.
  always_comb begin
    target = sync_level ? '0 : cyl_index;
    if (32'(target) == NUM_CYL - 1) begin
      next_idx = '0;
    end else begin
      next_idx = target + CYL_W'(1);
    end
  end

  // Decode the target cylinder and the outcome of firing it.
  always_comb begin
    target_oh = '0;
    for (int unsigned i = 0; i < NUM_CYL; i++) begin
      target_oh[i] = (32'(target) == i);
    end
    len_nonzero = (efi_len_us != 16'd0);
    fire_open   = len_nonzero ? target_oh : '0;
    fire_state  = len_nonzero ? StPulse : StArmed;
  end

  // Timeout and width-expiry qualifiers; an event always outranks a timeout.
  always_comb begin
    zero_cross  = pulse1m && (width_q == 16'd1);
    timeout_hit = (ign_timeout_len_20us != 16'd0) && (period_cnt_q >= ign_timeout_len_20us);
    stall_entry = efi_enable && !coil_rise && timeout_hit &&
                  ((state_q == StArmed) || (state_q == StPulse));
  end

  // Sequencer FSM with registered injector, index and status outputs.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q       <= StIdle;
      width_q       <= 16'd0;
      injector_open <= '0;
      puff_event    <= 1'b0;
      overlap_err   <= 1'b0;
      cyl_index     <= '0;
      stalled       <= 1'b0;
    end else begin
      puff_event  <= 1'b0;
      overlap_err <= 1'b0;
      if (!efi_enable) begin
        // Disabling is a silent close: no puff is reported.
        state_q       <= StIdle;
        width_q       <= 16'd0;
        injector_open <= '0;
        cyl_index     <= '0;
        stalled       <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StArmed;
          end
          StArmed: begin
            if (coil_rise) begin
              state_q       <= fire_state;
              injector_open <= fire_open;
              width_q       <= efi_len_us;
              cyl_index     <= next_idx;
            end else if (stall_entry) begin
              state_q <= StStalled;
              stalled <= 1'b1;
            end
          end
          StPulse: begin
            if (coil_rise) begin
              // Hand off directly to the next cylinder; a pulse ending on this
              // very tick is a normal close, not an overlap.
              puff_event    <= 1'b1;
              overlap_err   <= ~zero_cross;
              state_q       <= fire_state;
              injector_open <= fire_open;
              width_q       <= efi_len_us;
              cyl_index     <= next_idx;
            end else if (stall_entry) begin
              state_q       <= StStalled;
              injector_open <= '0;
              width_q       <= 16'd0;
              stalled       <= 1'b1;
            end else if (pulse1m) begin
              if (width_q == 16'd1) begin
                state_q       <= StArmed;
                injector_open <= '0;
                width_q       <= 16'd0;
                puff_event    <= 1'b1;
              end else begin
                width_q <= width_q - 16'd1;
              end
            end
          end
          StStalled: begin
            // The recovery event only restarts period measurement.
            if (coil_rise) begin
              state_q <= StArmed;
              stalled <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  // Measure event-to-event period; the first event after idle or stall only starts it.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      period_cnt_q    <= 16'd0;
      period_valid_q  <= 1'b0;
      ign_period_20us <= 16'd0;
    end else if (!efi_enable || (state_q == StIdle)) begin
      period_cnt_q   <= 16'd0;
      period_valid_q <= 1'b0;
    end else if (coil_rise) begin
      if (period_valid_q) begin
        ign_period_20us <= period_cnt_q;
      end
      period_valid_q <= 1'b1;
      period_cnt_q   <= 16'd0;
    end else begin
      if (stall_entry) begin
        period_valid_q <= 1'b0;
      end
      if (pulse50k && (period_cnt_q != PERIOD_SAT)) begin
        period_cnt_q <= period_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_efi_injector_sequencer.sv
// Directed bench for the injector sequencer. Time is scaled: 1 us = 2 sysclk cycles,
// so the 20 us tick arrives every 40 cycles.
module tb_efi_injector_sequencer;

  logic        sysclk = 1'b0;
  logic        sysreset;
  logic        pulse1m;
  logic        pulse50k;
  logic        efi_enable;
  logic        ign_coil;
  logic        cyl_sync;
  logic [15:0] efi_len_us;
  logic [15:0] ign_timeout_len_20us;
  logic [1:0]  injector_open;
  logic        puff_event;
  logic [0:0]  cyl_index;
  logic [15:0] ign_period_20us;
  logic        stalled;
  logic        overlap_err;

  int total = 0;
  int bad   = 0;

  efi_injector_sequencer #(
    .NUM_CYL    (2),
    .SYNC_STAGES(2)
  ) dut (
    .sysclk              (sysclk),
    .sysreset            (sysreset),
    .pulse1m             (pulse1m),
    .pulse50k            (pulse50k),
    .efi_enable          (efi_enable),
    .ign_coil            (ign_coil),
    .cyl_sync            (cyl_sync),
    .efi_len_us          (efi_len_us),
    .ign_timeout_len_20us(ign_timeout_len_20us),
    .injector_open       (injector_open),
    .puff_event          (puff_event),
    .cyl_index           (cyl_index),
    .ign_period_20us     (ign_period_20us),
    .stalled             (stalled),
    .overlap_err         (overlap_err)
  );

  always #5 sysclk = ~sysclk;

  // Realtime tick chain: pulse1m every 2 cycles, pulse50k every 40 cycles.
  int unsigned cyc = 0;
  initial begin
    pulse1m  = 1'b0;
    pulse50k = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      cyc++;
      pulse1m  = (cyc % 2 == 0);
      pulse50k = (cyc % 40 == 0);
    end
  end

  // Output monitor: puff/overlap counts, multi-hot detection and per-pulse runs.
  int         puff_cnt  = 0;
  int         ovl_cnt   = 0;
  int         multihot  = 0;
  int         handoffs  = 0;
  int         run_len   = 0;
  logic [1:0] prev_open = 2'b00;
  logic [1:0] bits_q[$];
  int         lens_q[$];
  initial begin
    forever begin
      @(negedge sysclk);
      if (puff_event) puff_cnt++;
      if (overlap_err) ovl_cnt++;
      if ($countones(injector_open) > 1) multihot++;
      if (injector_open !== prev_open) begin
        if (prev_open != 2'b00) begin
          bits_q.push_back(prev_open);
          lens_q.push_back(run_len);
          if (injector_open != 2'b00) handoffs++;
        end
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_open = injector_open;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_bits(input int idx);
    if (idx < bits_q.size()) return 32'(bits_q[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int get_len(input int idx);
    if (idx < lens_q.size()) return lens_q[idx];
    return -1;
  endfunction

  task automatic wait_us(input int n);
    repeat (2 * n) @(negedge sysclk);
  endtask

  // Park coil edges well away from the 20 us tick so period counts are exact.
  task automatic align();
    for (int k = 0; k < 41; k++) begin
      if (cyc % 40 == 20) break;
      @(negedge sysclk);
    end
  endtask

  int qi;
  int p0;
  int o0;
  int h0;
  int len;

  initial begin
    sysreset             = 1'b1;
    efi_enable           = 1'b0;
    ign_coil             = 1'b0;
    cyl_sync             = 1'b0;
    efi_len_us           = 16'd0;
    ign_timeout_len_20us = 16'd0;
    repeat (5) @(negedge sysclk);

    check_eq("rst open", 32'(injector_open), 0);
    check_eq("rst puff", 32'(puff_event), 0);
    check_eq("rst idx", 32'(cyl_index), 0);
    check_eq("rst period", 32'(ign_period_20us), 0);
    check_eq("rst stalled", 32'(stalled), 0);
    check_eq("rst overlap", 32'(overlap_err), 0);

    sysreset   = 1'b0;
    efi_len_us = 16'd300;
    efi_enable = 1'b1;
    wait_us(10);

    // Round-robin at 1000 us spacing with 300 us pulses.
    align();
    qi = bits_q.size();
    p0 = puff_cnt;
    o0 = ovl_cnt;
    for (int i = 0; i < 4; i++) begin
      ign_coil = 1'b1;
      wait_us(500);
      ign_coil = 1'b0;
      wait_us(500);
      check_eq("t1 period", 32'(ign_period_20us), (i == 0) ? 0 : 50);
    end
    check_eq("t1 npulse", bits_q.size() - qi, 4);
    for (int k = 0; k < 4; k++) begin
      check_eq("t1 bits", get_bits(qi + k), (k % 2 == 0) ? 1 : 2);
      len = get_len(qi + k);
      if (!(len >= 598 && len <= 600)) $display("t1 pulse %0d length %0d cycles", k, len);
      check_eq("t1 len ok", (len >= 598 && len <= 600), 1);
    end
    check_eq("t1 puffs", puff_cnt - p0, 4);
    check_eq("t1 overlaps", ovl_cnt - o0, 0);
    check_eq("t1 idx", 32'(cyl_index), 0);

    // Cylinder sync on the second event forces bit 0 out of turn.
    align();
    qi = bits_q.size();
    ign_coil = 1'b1;
    wait_us(500);
    ign_coil = 1'b0;
    wait_us(500);
    cyl_sync = 1'b1;
    wait_us(20);
    ign_coil = 1'b1;
    wait_us(20);
    cyl_sync = 1'b0;
    wait_us(480);
    ign_coil = 1'b0;
    wait_us(480);
    check_eq("t2 idx after sync", 32'(cyl_index), 1);
    ign_coil = 1'b1;
    wait_us(500);
    ign_coil = 1'b0;
    wait_us(500);
    check_eq("t2 bits0", get_bits(qi), 1);
    check_eq("t2 bits1", get_bits(qi + 1), 1);
    check_eq("t2 bits2", get_bits(qi + 2), 2);
    check_eq("t2 idx end", 32'(cyl_index), 0);

    // 800 us pulses at 500 us spacing: every pulse but the last is truncated.
    efi_len_us = 16'd800;
    align();
    qi = bits_q.size();
    p0 = puff_cnt;
    o0 = ovl_cnt;
    h0 = handoffs;
    for (int i = 0; i < 3; i++) begin
      ign_coil = 1'b1;
      wait_us(250);
      ign_coil = 1'b0;
      wait_us(250);
    end
    wait_us(900);
    check_eq("t3 npulse", bits_q.size() - qi, 3);
    check_eq("t3 bits0", get_bits(qi), 1);
    check_eq("t3 bits1", get_bits(qi + 1), 2);
    check_eq("t3 bits2", get_bits(qi + 2), 1);
    check_eq("t3 len0", get_len(qi), 1000);
    check_eq("t3 len1", get_len(qi + 1), 1000);
    len = get_len(qi + 2);
    check_eq("t3 len2 ok", (len >= 1598 && len <= 1600), 1);
    check_eq("t3 overlaps", ovl_cnt - o0, 2);
    check_eq("t3 puffs", puff_cnt - p0, 3);
    check_eq("t3 handoffs", handoffs - h0, 2);
    check_eq("t3 period", 32'(ign_period_20us), 25);

    // Stall: 400 us timeout, 700 us gap; a 600 us pulse is cut short silently.
    efi_len_us = 16'd600;
    align();
    p0 = puff_cnt;
    ign_coil = 1'b1;
    wait_us(20);
    ign_timeout_len_20us = 16'd20;
    wait_us(80);
    ign_coil = 1'b0;
    wait_us(200);
    check_eq("t4 not yet stalled", 32'(stalled), 0);
    check_eq("t4 open before stall", 32'(injector_open), 2);
    wait_us(200);
    check_eq("t4 stalled", 32'(stalled), 1);
    check_eq("t4 closed on stall", 32'(injector_open), 0);
    wait_us(200);
    check_eq("t4 no puff on stall", puff_cnt - p0, 0);
    ign_coil = 1'b1;
    wait_us(100);
    check_eq("t4 recover stalled", 32'(stalled), 0);
    check_eq("t4 recover no fire", 32'(injector_open), 0);
    check_eq("t4 recover idx", 32'(cyl_index), 0);
    ign_coil = 1'b0;
    wait_us(100);
    ign_coil = 1'b1;
    wait_us(100);
    check_eq("t4 fire after recover", 32'(injector_open), 1);
    check_eq("t4 idx after fire", 32'(cyl_index), 1);
    check_eq("t4 period after recover", 32'(ign_period_20us), 10);
    ign_timeout_len_20us = 16'd0;

    // Drop enable mid-pulse.
    wait_us(100);
    p0 = puff_cnt;
    efi_enable = 1'b0;
    @(negedge sysclk);
    check_eq("t5 closed", 32'(injector_open), 0);
    check_eq("t5 idx cleared", 32'(cyl_index), 0);
    wait_us(20);
    check_eq("t5 no puff", puff_cnt - p0, 0);
    ign_coil   = 1'b0;
    efi_enable = 1'b1;
    wait_us(20);
    align();
    ign_coil = 1'b1;
    wait_us(100);
    check_eq("t5 reenable fires bit0", 32'(injector_open), 1);
    check_eq("t5 period held", 32'(ign_period_20us), 10);

    // Asynchronous reset mid-pulse.
    sysreset = 1'b1;
    #1;
    check_eq("t6 async open", 32'(injector_open), 0);
    check_eq("t6 async idx", 32'(cyl_index), 0);
    check_eq("t6 async period", 32'(ign_period_20us), 0);
    @(negedge sysclk);
    efi_enable = 1'b0;
    ign_coil   = 1'b0;
    @(negedge sysclk);
    sysreset = 1'b0;
    wait_us(20);
    ign_coil = 1'b1;
    wait_us(100);
    check_eq("t6 idle no fire", 32'(injector_open), 0);
    ign_coil = 1'b0;
    wait_us(100);
    efi_enable = 1'b1;
    wait_us(20);
    ign_coil = 1'b1;
    wait_us(100);
    check_eq("t6 fire after enable", 32'(injector_open), 1);
    ign_coil = 1'b0;
    wait_us(700);
    check_eq("never multihot", multihot, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
